// File: rtl/game_physics_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : game_physics_core                                            |
// | Description : Frame-paced player physics, obstacle collision, lives and     |
// |               score for the runner game. Define GAME_INVULN_EN to build the |
// |               post-hit invulnerability window.                              |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module game_physics_core #(
  parameter int N_OBS         = 10,
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int UPPER_BOUND   = 20,
  parameter int LOWER_BOUND   = 460,
  parameter int PLAYER_SIZE   = 40,
  parameter int PLAYER_X      = 160,
  parameter int MAX_VELOCITY  = 10,
  parameter int ACCELERATION  = 1,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 90
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic [1:0]                   mode_sel,
  input  logic                         ctrl_up,
  input  logic [N_OBS*2*X_W-1:0]       obstacle_x,
  input  logic [N_OBS*2*Y_W-1:0]       obstacle_y,
  output logic [1:0]                   gamemode,
  output logic [Y_W-1:0]               player_y,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic [15:0]                  score,
  output logic                         hit,
  output logic                         invuln
);

  localparam int c_LIVES_W = $clog2(LIVES + 1);
  localparam int c_VEL_W   = $clog2(MAX_VELOCITY + ACCELERATION + 1);

  localparam logic [Y_W-1:0]       c_Y_TOP    = Y_W'(UPPER_BOUND);
  localparam logic [Y_W-1:0]       c_Y_BOT    = Y_W'(LOWER_BOUND - PLAYER_SIZE);
  localparam logic [Y_W-1:0]       c_Y_INIT   = Y_W'((UPPER_BOUND + LOWER_BOUND - PLAYER_SIZE) / 2);
  localparam logic [X_W:0]         c_PX_L     = (X_W+1)'(PLAYER_X);
  localparam logic [X_W:0]         c_PX_R     = (X_W+1)'(PLAYER_X + PLAYER_SIZE);
  localparam logic [c_VEL_W-1:0]   c_ACC      = c_VEL_W'(ACCELERATION);
  localparam logic [c_VEL_W-1:0]   c_MAXV     = c_VEL_W'(MAX_VELOCITY);
  localparam logic [c_LIVES_W-1:0] c_LIVES    = c_LIVES_W'(LIVES);
  localparam logic [c_LIVES_W-1:0] c_LIFE_ONE = c_LIVES_W'(1);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [Y_W-1:0]         r_y, w_y_nxt, w_y_upd;
  logic [c_VEL_W-1:0]     r_vel, w_vel_nxt, w_vel_upd;
  logic                   r_dir_up, w_dir_nxt, w_dir_upd;
  logic [c_LIVES_W-1:0]   r_lives, w_lives_nxt;
  logic [15:0]            r_score, w_score_nxt;
  logic                   r_hit, w_hit_nxt;

  logic                   w_restart, w_frame_run, w_blocked, w_take_hit, w_fatal;
  logic [N_OBS-1:0]       w_slot_hit;
  logic [Y_W:0]           w_py_bot;
  logic [c_VEL_W:0]       w_vel_sum;
  logic signed [Y_W+1:0]  w_y_delta, w_y_sum;

  assign w_restart   = (mode_sel == 2'b00);
  assign w_frame_run = frame_tick && (r_state == ST_RUN);
  assign w_py_bot    = {1'b0, r_y} + (Y_W+1)'(PLAYER_SIZE);

  // Strict AABB per slot against the pre-update position; left == right marks an empty slot.
  for (genvar k = 0; k < N_OBS; k++) begin : g_slot
    logic [X_W-1:0] w_left, w_right;
    logic [Y_W-1:0] w_top, w_bottom;
    assign w_left   = obstacle_x[k*2*X_W + X_W +: X_W];
    assign w_right  = obstacle_x[k*2*X_W       +: X_W];
    assign w_top    = obstacle_y[k*2*Y_W + Y_W +: Y_W];
    assign w_bottom = obstacle_y[k*2*Y_W       +: Y_W];
    assign w_slot_hit[k] = (w_left != w_right)
                        && (c_PX_R > {1'b0, w_left})
                        && (c_PX_L < {1'b0, w_right})
                        && (w_py_bot > {1'b0, w_top})
                        && (r_y < w_bottom);
  end

  assign w_take_hit = (|w_slot_hit) && !w_blocked;
  assign w_fatal    = w_take_hit && (r_lives == c_LIFE_ONE);

  always_comb begin
    w_dir_upd = r_dir_up;
    w_vel_upd = r_vel;
    w_y_upd   = r_y;
    w_vel_sum = {1'b0, r_vel} + {1'b0, c_ACC};
    if (ctrl_up == r_dir_up) begin
      w_vel_upd = (w_vel_sum > {1'b0, c_MAXV}) ? c_MAXV : w_vel_sum[c_VEL_W-1:0];
    end else if (r_vel < c_ACC) begin
      w_dir_upd = ctrl_up;
      w_vel_upd = c_ACC - r_vel;
    end else begin
      w_vel_upd = r_vel - c_ACC;
    end
    // Two guard bits keep the sum from wrapping past either edge before clamping.
    w_y_delta = $signed({{(Y_W+2-c_VEL_W){1'b0}}, w_vel_upd});
    w_y_sum   = w_dir_upd ? ($signed({2'b00, r_y}) - w_y_delta)
                          : ($signed({2'b00, r_y}) + w_y_delta);
    if (w_y_sum < $signed({2'b00, c_Y_TOP})) begin
      w_y_upd   = c_Y_TOP;
      w_vel_upd = '0;
    end else if (w_y_sum > $signed({2'b00, c_Y_BOT})) begin
      w_y_upd   = c_Y_BOT;
      w_vel_upd = '0;
    end else begin
      w_y_upd   = w_y_sum[Y_W-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_vel_nxt   = r_vel;
    w_dir_nxt   = r_dir_up;
    w_lives_nxt = r_lives;
    w_score_nxt = r_score;
    w_hit_nxt   = 1'b0;
    case (r_state)
      ST_START: if (mode_sel == 2'b01) w_state_nxt = ST_RUN;
      ST_RUN:   if (mode_sel[1])       w_state_nxt = ST_PAUSE;
      ST_PAUSE: if (mode_sel == 2'b01) w_state_nxt = ST_RUN;
      default:  w_state_nxt = r_state;
    endcase
    if (w_frame_run) begin
      if (w_take_hit) begin
        w_lives_nxt = r_lives - c_LIFE_ONE;
        w_hit_nxt   = 1'b1;
      end
      // The losing frame keeps the pre-hit position and does not score.
      if (w_fatal) begin
        w_state_nxt = ST_OVER;
      end else begin
        w_y_nxt   = w_y_upd;
        w_vel_nxt = w_vel_upd;
        w_dir_nxt = w_dir_upd;
        if (r_score != 16'hFFFF) w_score_nxt = r_score + 16'd1;
      end
    end
    if (w_restart) begin
      w_state_nxt = ST_START;
      w_y_nxt     = c_Y_INIT;
      w_vel_nxt   = '0;
      w_dir_nxt   = 1'b0;
      w_lives_nxt = c_LIVES;
      w_score_nxt = '0;
      w_hit_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_START;
      r_y      <= c_Y_INIT;
      r_vel    <= '0;
      r_dir_up <= 1'b0;
      r_lives  <= c_LIVES;
      r_score  <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_y      <= w_y_nxt;
      r_vel    <= w_vel_nxt;
      r_dir_up <= w_dir_nxt;
      r_lives  <= w_lives_nxt;
      r_score  <= w_score_nxt;
      r_hit    <= w_hit_nxt;
    end
  end

`ifdef GAME_INVULN_EN
  localparam int c_INV_W = $clog2(INVULN_FRAMES + 2);

  logic [c_INV_W-1:0] r_inv_cnt;
  logic               r_invuln;

  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_inv_cnt <= '0;
      r_invuln  <= 1'b0;
    end else if (w_frame_run && !w_fatal) begin
      if (w_take_hit) begin
        r_inv_cnt <= c_INV_W'(INVULN_FRAMES);
        r_invuln  <= (INVULN_FRAMES != 0);
      end else if (r_inv_cnt != '0) begin
        r_inv_cnt <= r_inv_cnt - c_INV_W'(1);
        r_invuln  <= (r_inv_cnt != c_INV_W'(1));
      end
    end
  end

  assign w_blocked = r_invuln;
  assign invuln    = r_invuln;
`else
  assign w_blocked = 1'b0;
  // Evaluates to 0 for every legal INVULN_FRAMES; the window is not built here.
  assign invuln    = (INVULN_FRAMES < 0);
`endif

  assign gamemode = r_state;
  assign player_y = r_y;
  assign lives    = r_lives;
  assign score    = r_score;
  assign hit      = r_hit;

endmodule
`default_nettype wire
